// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store sequencer over a word RAM; o_done 1-3 cycles after accept (err 1, sub-word store 3).
// No queueing: requests are only sampled in IDLE and ignored while o_busy is high.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_signed,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_rdata,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [31:0]           o_ram_data,
    output logic                  o_ram_write,
    output logic                  o_ram_read,
    input  logic [31:0]           i_ram_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t                r_state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [31:0]           r_rdata;
    logic                  r_ram_rd;
    logic                  r_ram_wr;
    logic [31:0]           r_ram_data;
    logic                  w_misaligned;

    assign w_misaligned = (i_size == SZ_ILL) ||
                          ((i_size == SZ_HALF) && i_addr[0]) ||
                          ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));

    // Right-align the addressed lane and extend it; word loads ignore the signed flag.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] lo);
        logic [31:0] shifted;
        shifted = word >> {lo, 3'b000};
        case (size)
            SZ_BYTE: extract = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SZ_HALF: extract = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: extract = word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                          input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] w;
        w = word;
        case (size)
            SZ_BYTE: w[{lo, 3'b000} +: 8]    = wdata[7:0];
            SZ_HALF: w[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_signed   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_ram_rd   <= 1'b0;
            r_ram_wr   <= 1'b0;
            r_ram_data <= '0;
        end else begin
            r_done   <= 1'b0;
            r_ram_rd <= 1'b0;
            r_ram_wr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_we     <= i_we;
                        r_size   <= i_size;
                        r_signed <= i_signed;
                        r_addr   <= i_addr;
                        r_wdata  <= i_wdata;
                        r_busy   <= 1'b1;
                        if (w_misaligned) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (i_we && (i_size == SZ_WORD)) begin
                            r_state    <= WRITE;
                            r_ram_wr   <= 1'b1;
                            r_ram_data <= i_wdata;
                        end else begin
                            r_state  <= READ;
                            r_ram_rd <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // Sub-word stores read-modify-write: merge into the fetched word here.
                    if (r_we) begin
                        r_state    <= WRITE;
                        r_ram_wr   <= 1'b1;
                        r_ram_data <= merge(i_ram_data, r_wdata, r_size, r_addr[1:0]);
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= extract(i_ram_data, r_size, r_signed, r_addr[1:0]);
                    end
                end
                WRITE: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_err   <= 1'b0;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_ram_addr  = {2'b00, r_addr[ADDR_WIDTH-1:2]};
    assign o_ram_data  = r_ram_data;
    assign o_ram_read  = r_ram_rd;
    // Gate with reset so a reset landing on the WRITE cycle never commits.
    assign o_ram_write = r_ram_wr & ~i_rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: small word RAM model, per-feature tasks with inline checks.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sgn = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, ram_write, ram_read;
    logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;

    logic [31:0] mem [16];
    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, viol_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_size(size),
        .i_signed(sgn), .i_addr(addr), .i_wdata(wdata),
        .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
        .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .o_ram_write(ram_write),
        .o_ram_read(ram_read), .i_ram_data(ram_rdata)
    );

    assign ram_rdata = mem[ram_addr[3:0]];

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr[3:0]] <= ram_wdata;
    end

    always @(negedge clk) begin
        if (ram_write) wr_cnt++;
        if (ram_read) rd_cnt++;
        if (done) done_cnt++;
        if ((ram_read && ram_write) || ((!busy || done) && (ram_read || ram_write))) viol_cnt++;
    end

    // Issue one request; lat counts edges from acceptance to the cycle o_done is seen.
    task automatic access(input logic w, input logic [1:0] sz, input logic s,
                          input logic [31:0] a, input logic [31:0] d, output int lat);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sgn = s; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = ~w; size = 2'b11; sgn = ~s; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        lat = 1;
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_done_err: got %b/%b expected 0/0", done, err); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        n_cmp++; if (ram_read !== 1'b0 || ram_write !== 1'b0) begin n_bad++; $display("FAIL reset_ram_strobes: got %b/%b expected 0/0", ram_read, ram_write); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_load();
        int lat;
        mem[1] = 32'h0000_0005;
        access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL word_load_lat: got %0d expected 2", lat); end
        n_cmp++; if (rdata !== 32'h0000_0005) begin n_bad++; $display("FAIL word_load_data: got %h expected 00000005", rdata); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL word_load_err: got %b expected 0", err); end
    endtask

    task automatic test_subword_load();
        int lat;
        mem[2] = 32'h1234_80F0;
        access(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL byte_load_lat: got %0d expected 2", lat); end
        n_cmp++; if (rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL byte_load_signed: got %h expected ffffff80", rdata); end
        access(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, lat);
        n_cmp++; if (rdata !== 32'h0000_1234) begin n_bad++; $display("FAIL half_load_unsigned: got %h expected 00001234", rdata); end
        access(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, lat);
        n_cmp++; if (rdata !== 32'h0000_00F0) begin n_bad++; $display("FAIL byte_load_unsigned: got %h expected 000000f0", rdata); end
        access(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, lat);
        n_cmp++; if (rdata !== 32'hFFFF_80F0) begin n_bad++; $display("FAIL half_load_signed: got %h expected ffff80f0", rdata); end
        access(1'b0, 2'b10, 1'b1, 32'h8, 32'h0, lat);
        n_cmp++; if (rdata !== 32'h1234_80F0) begin n_bad++; $display("FAIL word_load_ignores_signed: got %h expected 123480f0", rdata); end
    endtask

    task automatic test_stores();
        int lat, w0;
        mem[2] = 32'h1122_3344;
        w0 = wr_cnt;
        access(1'b1, 2'b00, 1'b0, 32'hA, 32'h0000_00AB, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL byte_store_lat: got %0d expected 3", lat); end
        n_cmp++; if (mem[2] !== 32'h11AB_3344) begin n_bad++; $display("FAIL byte_store_mem: got %h expected 11ab3344", mem[2]); end
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL byte_store_writes: got %0d expected 1", wr_cnt - w0); end
        mem[1] = 32'h0000_0005;
        access(1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF_BEEF, lat);
        n_cmp++; if (mem[1] !== 32'hBEEF_0005) begin n_bad++; $display("FAIL half_store_mem: got %h expected beef0005", mem[1]); end
        access(1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFE_F00D, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL word_store_lat: got %0d expected 2", lat); end
        n_cmp++; if (mem[3] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL word_store_mem: got %h expected cafef00d", mem[3]); end
    endtask

    task automatic test_errors();
        int lat, r0, w0;
        mem[1] = 32'h0000_0005;
        access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat);
        r0 = rd_cnt; w0 = wr_cnt;
        access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL misaligned_lat: got %0d expected 1", lat); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL misaligned_err: got %b expected 1", err); end
        n_cmp++; if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL misaligned_ram: got %0d reads %0d writes expected 0/0", rd_cnt - r0, wr_cnt - w0); end
        n_cmp++; if (rdata !== 32'h0000_0005) begin n_bad++; $display("FAIL err_rdata_held: got %h expected 00000005", rdata); end
        mem[0] = 32'h0102_0304;
        access(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_7777, lat);
        n_cmp++; if (err !== 1'b1 || mem[0] !== 32'h0102_0304) begin n_bad++; $display("FAIL half_misaligned_store: got err %b mem %h expected 1 01020304", err, mem[0]); end
        access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat);
        n_cmp++; if (err !== 1'b1 || lat !== 1) begin n_bad++; $display("FAIL illegal_size: got err %b lat %0d expected 1/1", err, lat); end
        access(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, lat);
        n_cmp++; if (err !== 1'b0 || rdata !== 32'h0000_0001) begin n_bad++; $display("FAIL err_clears: got err %b data %h expected 0 00000001", err, rdata); end
    endtask

    task automatic test_reset_mid_write();
        int d0;
        mem[0] = 32'h0102_0304;
        d0 = done_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_write_busy: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (mem[0] !== 32'h0102_0304) begin n_bad++; $display("FAIL rst_mid_write_mem: got %h expected 01020304", mem[0]); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL rst_mid_write_done: got %0d expected 0", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int d0;
        mem[0] = 32'h0A0B_0C0D;
        mem[5] = 32'h0000_7E57;
        d0 = done_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h14; wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        we = 1'b1; addr = 32'h0; wdata = 32'h5555_5555;
        repeat (2) @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt - d0); end
        n_cmp++; if (mem[0] !== 32'h0A0B_0C0D) begin n_bad++; $display("FAIL b2b_ignored_store: got %h expected 0a0b0c0d", mem[0]); end
        n_cmp++; if (rdata !== 32'h0000_7E57 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_result: got %h busy %b expected 00007e57 0", rdata, busy); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_word_load();
        test_subword_load();
        test_stores();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        n_cmp++; if (viol_cnt !== 0) begin n_bad++; $display("FAIL ram_strobe_rules: got %0d violations expected 0", viol_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, is the width of the CPU byte address and of the RAM word-index port.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req  input  1  CPU access request; sampled only in IDLE.
REQ-005 i_we  input  1  1 = store, 0 = load.
REQ-006 i_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 i_signed  input  1  load sign-extension enable (byte/halfword only).
REQ-008 i_addr  input  ADDR_WIDTH  CPU byte address.
REQ-009 i_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_done  output  1  one-cycle completion pulse.
REQ-012 o_err  output  1  misaligned/illegal access flag, valid with o_done.
REQ-013 o_rdata  output  32  load result, valid with o_done and held until the next completion.
REQ-014 o_ram_addr  output  ADDR_WIDTH  RAM word index = {2'b00, addr[ADDR_WIDTH-1:2]}.
REQ-015 o_ram_data  output  32  RAM write data.
REQ-016 o_ram_write  output  1  RAM write strobe; the RAM commits on the next i_clk edge.
REQ-017 o_ram_read  output  1  RAM read enable; the RAM returns data combinationally.
REQ-018 i_ram_data  input  32  RAM read data.

Function
REQ-019 The FSM SHALL use the states IDLE, READ, WRITE and DONE; i_addr, i_size, i_we, i_signed and i_wdata SHALL be latched when i_req=1 in IDLE.
REQ-020 Acceptance transitions:
- misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) or i_size=11 -> DONE with o_err=1, no RAM access;
- word store -> WRITE;
- any load or sub-word store -> READ.
REQ-021 READ SHALL assert o_ram_read=1 and capture i_ram_data at the end of the cycle; it then goes to DONE for a load or to WRITE for a sub-word store.
REQ-022 WRITE SHALL assert o_ram_write=1 with o_ram_data equal to the full word (word store) or the captured word with only the addressed lane(s) replaced (sub-word store), then go to DONE.
REQ-023 Byte lanes SHALL be little-endian: byte lane = addr[1:0] at bits [8*lane+7:8*lane]; halfword lane = addr[1] at bits [16*addr[1]+15:16*addr[1]].
REQ-024 Loads SHALL extract the addressed lane right-aligned in o_rdata, zero-extended when i_signed=0 and sign-extended when i_signed=1; word loads SHALL ignore i_signed.
REQ-025 DONE SHALL pulse o_done=1 for exactly one cycle, then return to IDLE; o_err SHALL be 0 for successful accesses.
REQ-026 Latency from the accepting edge to o_done:
- word load, 2 cycles;
- word store, 2 cycles;
- sub-word load, 2 cycles;
- sub-word store, 3 cycles;
- error, 1 cycle.
REQ-027 o_ram_read and o_ram_write SHALL never be high together and SHALL both be 0 in IDLE and DONE.
REQ-028 i_req while o_busy=1 SHALL be ignored and not queued; a new request SHALL be accepted no earlier than the cycle after o_done.
REQ-029 On an error completion, o_rdata SHALL keep its previous value.

Reset
REQ-030 When i_rst=1 at an edge, the state SHALL become IDLE and o_busy, o_done, o_err, o_rdata, o_ram_read and o_ram_write SHALL become 0.
REQ-031 o_ram_write SHALL be gated combinationally by ~i_rst so that no RAM write commits at an edge where i_rst=1, including reset asserted mid-WRITE.
REQ-032 An access interrupted by reset SHALL produce no o_done, and the RAM contents SHALL be unchanged unless its write edge had already passed.

Verification
REQ-033 RAM word 1 = 0x00000005; load word at addr 0x4 -> o_done 2 cycles after accept, o_rdata=0x00000005, o_err=0.
REQ-034 RAM word 2 = 0x123480F0; byte load at addr 0x9, signed=1 -> o_rdata=0xFFFFFF80; halfword load at 0xA, signed=0 -> 0x00001234.
REQ-035 RAM word 2 = 0x11223344; byte store 0xAB at addr 0xA -> o_done 3 cycles after accept, word 2 = 0x11AB3344, exactly one o_ram_write cycle.
REQ-036 Word load at addr 0x6 -> o_done and o_err 1 cycle after accept, o_ram_read and o_ram_write never asserted.
REQ-037 Word store 0xDEADBEEF at 0x0 with i_rst=1 during the WRITE cycle -> word 0 unchanged, no o_done, o_busy=0 next cycle.
REQ-038 i_req pulsed again while o_busy=1 -> ignored; exactly one o_done per accepted request.
